// File: rtl/pio_pkg.sv
// pio_pkg: constants shared between the pio block and its host sequencer.
//   - pio action codes (NONE .. IN_SYNC_BYPASS, 0-25)
//   - host sequencer FSM state encoding
//   - host request address field positions
package pio_pkg;

    // pio action codes
    localparam logic [5:0] ACT_NONE           = 6'd0;
    localparam logic [5:0] ACT_INSTR          = 6'd1;
    localparam logic [5:0] ACT_WR_CTRL        = 6'd2;
    localparam logic [5:0] ACT_PULL           = 6'd3;
    localparam logic [5:0] ACT_PUSH           = 6'd4;
    localparam logic [5:0] ACT_WR_CLKDIV      = 6'd5;
    localparam logic [5:0] ACT_WR_EXECCTRL    = 6'd6;
    localparam logic [5:0] ACT_WR_SHIFTCTRL   = 6'd7;
    localparam logic [5:0] ACT_WR_PINCTRL     = 6'd8;
    localparam logic [5:0] ACT_EXEC           = 6'd9;
    localparam logic [5:0] ACT_WR_INPUT_SYNC  = 6'd10;
    localparam logic [5:0] ACT_RD_IRQ         = 6'd11;
    localparam logic [5:0] ACT_RD_FSTAT       = 6'd12;
    localparam logic [5:0] ACT_RD_FDEBUG      = 6'd13;
    localparam logic [5:0] ACT_RD_FLEVEL      = 6'd14;
    localparam logic [5:0] ACT_RD_ADDR        = 6'd15;
    localparam logic [5:0] ACT_RD_INSTR       = 6'd16;
    localparam logic [5:0] ACT_RD_IRQ0_INTS   = 6'd17;
    localparam logic [5:0] ACT_RD_IRQ1_INTS   = 6'd18;
    localparam logic [5:0] ACT_WR_IRQ         = 6'd19;
    localparam logic [5:0] ACT_WR_IRQ_FORCE   = 6'd20;
    localparam logic [5:0] ACT_WR_IRQ0_INTE   = 6'd21;
    localparam logic [5:0] ACT_WR_IRQ1_INTE   = 6'd22;
    localparam logic [5:0] ACT_WR_IRQ0_INTF   = 6'd23;
    localparam logic [5:0] ACT_WR_IRQ1_INTF   = 6'd24;
    localparam logic [5:0] ACT_IN_SYNC_BYPASS = 6'd25;
    localparam logic [5:0] ACT_MAX            = ACT_IN_SYNC_BYPASS;

    // host sequencer states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DECODE  = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_ISSUE   = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

    // host address fields
    localparam int ADDR_INSTR_BIT = 7;   // 1: instruction-memory write
    localparam int ADDR_MIDX_HI   = 6;
    localparam int ADDR_MIDX_LO   = 5;
    localparam int ADDR_FIELD_HI  = 4;   // action or instr index, [4:0]

endpackage

// File: rtl/pio_host_ctrl.sv
// pio_host_ctrl: single-outstanding host sequencer in front of pio.
// Turns one host request into one single-cycle pio strobe, waits on
// TX-full / RX-empty for PUSH / PULL with a bounded timeout, captures
// pio_dout for reads and returns exactly one response per request.
// Ports:
//   clk, reset                 clock, async active-high reset
//   req_valid/ready/write/addr/wdata   host request channel
//   rsp_valid/ready/rdata/err          host response channel
//   pio_action/mindex/index/din        strobe to pio (action 0 when idle)
//   pio_dout                   pio read data, valid the cycle after the strobe
//   tx_full, rx_empty          per-SM FIFO status from pio
module pio_host_ctrl
    import pio_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [5:0]  pio_action,
    output logic [1:0]  pio_mindex,
    output logic [4:0]  pio_index,
    output logic [31:0] pio_din,
    input  logic [31:0] pio_dout,
    input  logic [3:0]  tx_full,
    input  logic [3:0]  rx_empty
);

    localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TIMEOUT);

    logic [2:0]    state, state_n;
    logic          lat_write;
    logic [7:0]    lat_addr;
    logic [31:0]   lat_wdata;
    logic [TO_W-1:0] cnt;
    logic [TO_W:0] cnt_inc;
    logic          is_instr, legal, blocked, fail;
    logic [5:0]    act;
    logic [1:0]    midx;

    // Reads are legal only on read-only actions, writes only on the rest;
    // instruction-memory space is write-only.
    function automatic logic access_ok(input logic wr, input logic [7:0] addr);
        logic [5:0] a;
        logic       ro;
        a  = {1'b0, addr[ADDR_FIELD_HI:0]};
        ro = (a == ACT_NONE) || (a == ACT_PULL) ||
             (a >= ACT_RD_IRQ && a <= ACT_RD_IRQ1_INTS);
        if (addr[ADDR_INSTR_BIT])
            access_ok = wr;
        else if (a > ACT_MAX)
            access_ok = 1'b0;
        else
            access_ok = wr ? !ro : ro;
    endfunction

    assign is_instr = lat_addr[ADDR_INSTR_BIT];
    assign act      = is_instr ? ACT_INSTR : {1'b0, lat_addr[ADDR_FIELD_HI:0]};
    assign midx     = is_instr ? 2'd0 : lat_addr[ADDR_MIDX_HI:ADDR_MIDX_LO];
    assign legal    = access_ok(lat_write, lat_addr);
    assign blocked  = (act == ACT_PUSH && tx_full[midx]) ||
                      (act == ACT_PULL && rx_empty[midx]);
    assign cnt_inc  = {1'b0, cnt} + 1'b1;

    always_comb begin
        state_n = state;
        fail    = 1'b0;
        case (state)
            ST_IDLE:
                if (req_valid && req_ready) state_n = ST_DECODE;
            ST_DECODE: begin
                if (!legal) begin
                    state_n = ST_RESP;
                    fail    = 1'b1;
                end else if (blocked) begin
                    if (TIMEOUT == 0) begin
                        state_n = ST_RESP;
                        fail    = 1'b1;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end else begin
                    state_n = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // release wins over timeout on the same cycle
                if (!blocked) begin
                    state_n = ST_ISSUE;
                end else if (cnt_inc >= TO_LIM) begin
                    state_n = ST_RESP;
                    fail    = 1'b1;
                end
            end
            ST_ISSUE:   state_n = ST_CAPTURE;
            ST_CAPTURE: state_n = ST_RESP;
            ST_RESP:
                if (rsp_ready) state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            pio_action <= ACT_NONE;
            pio_mindex <= '0;
            pio_index  <= '0;
            pio_din    <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
        end else begin
            state     <= state_n;
            req_ready <= (state_n == ST_IDLE);
            rsp_valid <= (state_n == ST_RESP);

            if (state == ST_IDLE && req_valid && req_ready) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end

            if (state == ST_DECODE)
                cnt <= '0;
            else if (state == ST_WAIT && blocked && cnt != '1)
                cnt <= cnt + 1'b1;

            // strobe is registered on entry to ISSUE, so it lives exactly one cycle
            if (state_n == ST_ISSUE) begin
                pio_action <= act;
                pio_mindex <= midx;
                pio_index  <= is_instr ? lat_addr[ADDR_FIELD_HI:0] : 5'd0;
                pio_din    <= lat_write ? lat_wdata : 32'd0;
            end else begin
                pio_action <= ACT_NONE;
                pio_mindex <= '0;
                pio_index  <= '0;
                pio_din    <= '0;
            end

            if (state == ST_CAPTURE) begin
                rsp_rdata <= lat_write ? 32'd0 : pio_dout;
                rsp_err   <= 1'b0;
            end else if (fail) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end else if (state == ST_RESP && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pio_host_ctrl.sv
// Bench for pio_host_ctrl: directed requests, a cycle-timeline model of
// each request, and one per-cycle compare process.
module tb_pio_host_ctrl;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata;
    logic [5:0]  pio_action;
    logic [1:0]  pio_mindex;
    logic [4:0]  pio_index;
    logic [31:0] pio_din, pio_dout = '0;
    logic [3:0]  tx_full = '0, rx_empty = '0;

    pio_host_ctrl #(.TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .pio_action(pio_action), .pio_mindex(pio_mindex), .pio_index(pio_index),
        .pio_din(pio_din), .pio_dout(pio_dout),
        .tx_full(tx_full), .rx_empty(rx_empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // expected timeline of the current request
    bit          active = 0, done = 0, has_stb = 0;
    int          acc_cyc = 0, stb_cyc = 0, rsp_cyc = 0;
    logic [5:0]  e_act;
    logic [1:0]  e_midx;
    logic [4:0]  e_idx;
    logic [31:0] e_din, e_rdata;
    logic        e_err;

    // observations, used by the literal per-test checks
    int          o_rsp, o_stb_n, o_stb_cyc;
    logic [31:0] o_rdata;
    logic        o_err;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    function automatic bit m_legal(input bit w, input logic [7:0] a);
        int  act;
        bit  ro;
        if (a[7]) return w;
        act = int'(a[4:0]);
        if (act > 25) return 1'b0;
        ro = (act == 0) || (act == 3) || (act >= 11 && act <= 18);
        return w ? !ro : ro;
    endfunction

    always @(negedge clk) begin
        bit sv, ev;
        sv = active && has_stb && (cyc == stb_cyc);
        ev = active && (cyc >= rsp_cyc);
        chk("pio_action", 32'(pio_action), sv ? 32'(e_act)  : 32'd0);
        chk("pio_mindex", 32'(pio_mindex), sv ? 32'(e_midx) : 32'd0);
        chk("pio_index",  32'(pio_index),  sv ? 32'(e_idx)  : 32'd0);
        chk("pio_din",    pio_din,         sv ? e_din       : 32'd0);
        chk("req_ready",  32'(req_ready),  32'(!active || cyc == acc_cyc));
        chk("rsp_valid",  32'(rsp_valid),  32'(ev));
        if (ev) begin
            chk("rsp_rdata", rsp_rdata,     e_rdata);
            chk("rsp_err",   32'(rsp_err),  32'(e_err));
        end
        if (reset) begin
            chk("rst_rdata", rsp_rdata,    32'd0);
            chk("rst_err",   32'(rsp_err), 32'd0);
        end
        if (active) begin
            if (pio_action != 6'd0) begin
                o_stb_n++;
                o_stb_cyc = cyc;
            end
            if (rsp_valid && o_rsp < 0) begin
                o_rsp   = cyc;
                o_rdata = rsp_rdata;
                o_err   = rsp_err;
            end
        end
        if (ev && rsp_ready) begin
            active = 0;
            done   = 1;
        end
    end

    // Called #1 after a rising edge. hold = cycles after decode the FIFO
    // status stays asserted; rwait = extra cycles rsp_ready is held low;
    // abort_at > 0 pulses reset that many cycles after accept.
    task automatic run_req(input bit w, input logic [7:0] a, input logic [31:0] wd,
                           input logic [3:0] tx, input logic [3:0] rx, input int hold,
                           input int rwait, input logic [31:0] dout, input int abort_at);
        int act_i, m, n;
        bit lg, rel;
        req_valid = 1; req_write = w; req_addr = a; req_wdata = wd;
        tx_full = tx; rx_empty = rx; pio_dout = dout;
        acc_cyc = cyc; done = 0;
        o_rsp = -1; o_stb_n = 0; o_stb_cyc = -1; o_rdata = 'x; o_err = 1'bx;

        lg    = m_legal(w, a);
        act_i = a[7] ? 1 : int'(a[4:0]);
        m     = a[7] ? 0 : int'(a[6:5]);
        rel   = lg && hold > 0 && ((act_i == 4 && tx[m]) || (act_i == 3 && rx[m]));
        has_stb = 0; e_err = 0; e_rdata = 32'd0;
        if (!lg) begin
            rsp_cyc = acc_cyc + 2; e_err = 1;
        end else if (!rel) begin
            has_stb = 1; stb_cyc = acc_cyc + 2; rsp_cyc = acc_cyc + 4;
        end else if (hold <= TO) begin
            has_stb = 1; stb_cyc = acc_cyc + hold + 2; rsp_cyc = acc_cyc + hold + 4;
        end else begin
            rsp_cyc = acc_cyc + 2 + TO; e_err = 1;
        end
        e_act  = 6'(act_i);
        e_midx = 2'(m);
        e_idx  = a[7] ? a[4:0] : 5'd0;
        e_din  = w ? wd : 32'd0;
        if (has_stb && !w) e_rdata = dout;
        active = 1;

        @(posedge clk); #1;
        req_valid = 0;
        n = 0;
        while (!done) begin
            if (abort_at > 0 && cyc == acc_cyc + abort_at) begin
                reset = 1; active = 0; tx_full = '0; rx_empty = '0; rsp_ready = 0;
                repeat (2) @(posedge clk);
                #1 reset = 0;
                return;
            end
            if (cyc == acc_cyc + 1 + hold) begin
                tx_full = '0; rx_empty = '0;
            end
            rsp_ready = (cyc >= rsp_cyc + rwait);
            if (n++ > 700) begin
                total++; bad++;
                $display("FAIL bound cyc=%0d got=no_handshake exp=handshake", cyc);
                active = 0;
                break;
            end
            @(posedge clk); #1;
        end
        rsp_ready = 0; tx_full = '0; rx_empty = '0;
    endtask

    // illegal accesses: {write, addr}
    logic [8:0] ill [7];

    initial begin
        ill = '{9'h10B, 9'h013, 9'h11F, 9'h01F, 9'h085, 9'h11A, 9'h100};
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // read NONE
        run_req(0, 8'h00, 32'd0, 4'h0, 4'h0, 0, 0, 32'h0100_0000, 0);
        chk("t1_lat",   32'(o_rsp - acc_cyc), 32'd4);
        chk("t1_rdata", o_rdata, 32'h0100_0000);
        chk("t1_nstb",  32'(o_stb_n), 32'd0);

        // instruction write, index 4
        run_req(1, 8'h84, 32'h0000_E001, 4'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 0);
        chk("t2_nstb",  32'(o_stb_n), 32'd1);
        chk("t2_stb",   32'(o_stb_cyc - acc_cyc), 32'd2);
        chk("t2_lat",   32'(o_rsp - acc_cyc), 32'd4);
        chk("t2_rdata", o_rdata, 32'd0);

        // PUSH to SM2 blocked 10 cycles
        run_req(1, 8'h44, 32'hCAFE_0002, 4'b0100, 4'h0, 10, 0, 32'd0, 0);
        chk("t3_nstb", 32'(o_stb_n), 32'd1);
        chk("t3_stb",  32'(o_stb_cyc - acc_cyc), 32'd12);
        chk("t3_lat",  32'(o_rsp - acc_cyc), 32'd14);
        chk("t3_err",  32'(o_err), 32'd0);

        // PULL from SM1 never released: timeout
        run_req(0, 8'h23, 32'd0, 4'h0, 4'b0010, 1000, 0, 32'h5555_5555, 0);
        chk("t4_lat",  32'(o_rsp - acc_cyc), 32'd257);
        chk("t4_err",  32'(o_err), 32'd1);
        chk("t4_nstb", 32'(o_stb_n), 32'd0);

        foreach (ill[i]) begin
            run_req(ill[i][8], ill[i][7:0], 32'h1234_0000, 4'h0, 4'h0, 0, 0, 32'h9999_9999, 0);
            chk("ill_lat",  32'(o_rsp - acc_cyc), 32'd2);
            chk("ill_err",  32'(o_err), 32'd1);
            chk("ill_nstb", 32'(o_stb_n), 32'd0);
        end

        // PULL SM1 with other SMs empty, slow rsp_ready
        run_req(0, 8'h23, 32'd0, 4'h0, 4'b1101, 5, 3, 32'h1234_5678, 0);
        chk("t10_lat",   32'(o_rsp - acc_cyc), 32'd4);
        chk("t10_rdata", o_rdata, 32'h1234_5678);

        // PUSH SM0 with other SMs full
        run_req(1, 8'h04, 32'h0000_00A0, 4'b1110, 4'h0, 1000, 0, 32'd0, 0);
        chk("t11_lat", 32'(o_rsp - acc_cyc), 32'd4);

        // highest legal action
        run_req(1, 8'h19, 32'h0000_0003, 4'h0, 4'h0, 0, 0, 32'd0, 0);
        chk("t12_err", 32'(o_err), 32'd0);
        chk("t12_stb", 32'(o_stb_cyc - acc_cyc), 32'd2);

        // reset while waiting on SM3 TX-full
        run_req(1, 8'h64, 32'h0000_0777, 4'b1000, 4'h0, 1000, 0, 32'd0, 5);
        chk("t13_nstb",  32'(o_stb_n), 32'd0);
        chk("t13_norsp", 32'(o_rsp), 32'hFFFF_FFFF);

        // normal read afterwards
        run_req(0, 8'h11, 32'd0, 4'h0, 4'h0, 0, 0, 32'hA5A5_A5A5, 0);
        chk("t14_lat",   32'(o_rsp - acc_cyc), 32'd4);
        chk("t14_rdata", o_rdata, 32'hA5A5_A5A5);

        // PULL SM0 blocked 3 cycles
        run_req(0, 8'h03, 32'd0, 4'h0, 4'b0001, 3, 0, 32'h0000_0077, 0);
        chk("t15_stb",   32'(o_stb_cyc - acc_cyc), 32'd5);
        chk("t15_lat",   32'(o_rsp - acc_cyc), 32'd7);
        chk("t15_rdata", o_rdata, 32'h0000_0077);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
